// File: rtl/sram_port_arbiter_if.sv
// Client-side bus of the SRAM port arbiter: per-port request/grant/read-return.
interface sram_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024
);
  localparam int AW       = $clog2(NUM_WORDS);
  localparam int BE_WIDTH = (DATA_WIDTH + 7) / 8;

  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            lock_i;
  logic [NUM_PORTS-1:0]            we_i;
  logic [NUM_PORTS*AW-1:0]         addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS*BE_WIDTH-1:0]   be_i;
  logic [NUM_PORTS-1:0]            gnt_o;
  logic [NUM_PORTS-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]           rdata_o;

  // Clients drive requests and consume grants / read data.
  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  // The arbiter consumes requests and produces grants / read data.
  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_PORTS clients,
// with per-port lock for back-to-back beats and 1-cycle read-data routing.
module sram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  sram_port_arbiter_if.slave         bus,
  output logic                       sram_req_o,
  output logic                       sram_we_o,
  output logic [$clog2(NUM_WORDS)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]      sram_wdata_o,
  output logic [(DATA_WIDTH+7)/8-1:0] sram_be_o,
  input  logic [DATA_WIDTH-1:0]      sram_rdata_i
);
  localparam int AW       = $clog2(NUM_WORDS);
  localparam int BE_WIDTH = (DATA_WIDTH + 7) / 8;
  localparam int IW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IW-1:0]        prio_q, lock_owner_q, rid_q;
  logic                 lock_vld_q, rvalid_q;
  logic [IW-1:0]        win, prio_nxt;
  logic                 found, rd_xfer;
  logic [NUM_PORTS-1:0] gnt;
  int                   idx;

  // Pick the winner: a locked owner is the only candidate, otherwise scan
  // from prio_q with wrap. Reset masks every grant.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    if (rst_i) begin
      found = 1'b0;
    end else if (lock_vld_q) begin
      found = bus.req_i[lock_owner_q];
      win   = lock_owner_q;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = int'(prio_q) + i;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && bus.req_i[idx]) begin
          found = 1'b1;
          win   = IW'(idx);
        end
      end
    end
  end

  // Grant vector and SRAM command mux; everything zero when nobody wins.
  always_comb begin
    gnt          = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (found) begin
      gnt[win]     = 1'b1;
      sram_req_o   = 1'b1;
      sram_we_o    = bus.we_i[win];
      sram_addr_o  = bus.addr_i[int'(win)*AW +: AW];
      sram_wdata_o = bus.wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      sram_be_o    = bus.be_i[int'(win)*BE_WIDTH +: BE_WIDTH];
    end
  end

  assign rd_xfer  = found & ~bus.we_i[win];
  assign prio_nxt = (win == IW'(NUM_PORTS - 1)) ? '0 : win + IW'(1);

  // Priority / lock state: a locked transfer pins the owner; an unlocked
  // transfer rotates priority past the winner; an idle owner loses its lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q       <= '0;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
    end else if (found) begin
      if (bus.lock_i[win]) begin
        lock_vld_q   <= 1'b1;
        lock_owner_q <= win;
      end else begin
        lock_vld_q <= 1'b0;
        prio_q     <= prio_nxt;
      end
    end else if (lock_vld_q) begin
      // Owner is not requesting (otherwise it would have won): release.
      lock_vld_q <= 1'b0;
    end
  end

  // Read-return tracking: the SRAM answers exactly one cycle after a read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= rd_xfer;
      if (rd_xfer) rid_q <= win;
    end
  end

  assign bus.gnt_o   = gnt;
  assign bus.rdata_o = sram_rdata_i;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_rv
    assign bus.rvalid_o[k] = rvalid_q && (rid_q == IW'(k));
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port `sram` instance between NUM_PORTS requesters with a per-port req/gnt/rvalid protocol.
- Sits between cache/PTW-style clients and the SRAM macro wrapper.
- Round-robin arbitration; an optional per-port lock lets a client hold the SRAM for back-to-back beats.
- Tracks the 1-cycle SRAM read latency and routes read data back to the owner.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- DATA_WIDTH, 64, SRAM word width.
- NUM_WORDS, 1024, SRAM depth; AW = $clog2(NUM_WORDS).
- BE_WIDTH (localparam), (DATA_WIDTH+7)/8, byte-enable width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_i  in  NUM_PORTS  per-port request
- lock_i  in  NUM_PORTS  per-port lock; keep priority after this grant
- we_i  in  NUM_PORTS  per-port write enable
- addr_i  in  NUM_PORTS*AW  per-port address; port k at [k*AW +: AW]
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data
- be_i  in  NUM_PORTS*BE_WIDTH  per-port byte enables
- gnt_o  out  NUM_PORTS  one-hot grant, combinational
- rvalid_o  out  NUM_PORTS  one-hot read-data-valid
- rdata_o  out  DATA_WIDTH  read data, broadcast to all ports; meaningful only with rvalid_o
- sram_req_o  out  1  to SRAM req_i
- sram_we_o  out  1  to SRAM we_i
- sram_addr_o  out  AW  to SRAM addr_i
- sram_wdata_o  out  DATA_WIDTH  to SRAM wdata_i
- sram_be_o  out  BE_WIDTH  to SRAM be_i
- sram_rdata_i  in  DATA_WIDTH  from SRAM rdata_o; valid the cycle after a read request

Behaviour:
- Reset (rst_i high, async):
  - prio_q = 0, lock_owner_q = none, rvalid_q = 0, rid_q = 0.
  - gnt_o and sram_req_o forced 0 while rst_i is high.
  - rvalid_o = 0.
- Arbitration (combinational, same cycle):
  - If lock_owner_q = k is valid, only port k may be granted. Other ports see gnt 0 even when requesting.
  - Otherwise scan ports starting at prio_q, wrapping modulo NUM_PORTS. The first asserted req_i wins.
  - gnt_o has at most one bit set.
  - sram_req_o = |gnt_o.
  - sram_we_o/addr_o/wdata_o/be_o are muxed from the winner. They are all-zero when there is no grant.
- Handshake:
  - A transfer occurs when req_i[k] & gnt_o[k].
  - A requester must hold we/addr/wdata/be stable until it is granted.
  - Deasserting req_i before the grant is permitted; no transfer occurs.
- Priority update, on each transfer by port k:
  - If lock_i[k] = 1: lock_owner_q <= k, prio_q unchanged.
  - If lock_i[k] = 0: lock_owner_q <= none, prio_q <= (k+1) mod NUM_PORTS.
  - A locked owner that deasserts req_i releases the lock next cycle (lock_owner_q <= none); prio_q is unchanged.
  - No transfer and no lock: state holds.
- Read return:
  - A read transfer (we = 0) by port k sets rvalid_q <= 1 and rid_q <= k.
  - Any other cycle clears rvalid_q.
  - rvalid_o = rvalid_q ? onehot(rid_q) : 0. rdata_o = sram_rdata_i.
  - Read latency is exactly 1 cycle, for every read including back-to-back reads.
  - Writes never produce rvalid.
- Throughput: one transfer per cycle; no bubbles between consecutive grants.
- Boundary conditions:
  - All req_i low: no SRAM access; rdata_o still passes sram_rdata_i.
  - Simultaneous rvalid for an earlier read and a new grant is legal; they are independent.
  - prio_q wraps from NUM_PORTS-1 to 0.
  - Reset mid-read: a pending rvalid is dropped and never delivered.
  - lock_i without a grant has no effect.

Test Plan:
- Reset: rst_i high, all req_i = 1 -> gnt_o = 0, sram_req_o = 0, rvalid_o = 0. After release, first grant goes to port 0.
- Round-robin: NUM_PORTS = 2, both ports continuously read addr 0x10 / 0x20 for 4 cycles -> gnt_o = 01,10,01,10. sram_addr_o = 0x10,0x20,0x10,0x20. rvalid_o = 01,10,01,10, each one cycle later with matching data.
- Write then read: port 1 writes 0xDEADBEEF_CAFEF00D, be = 0xFF, to addr 5; next cycle port 1 reads addr 5 -> no rvalid for the write; rvalid_o = 10 and rdata_o = 0xDEADBEEFCAFEF00D two cycles after the write.
- Lock: port 0 requests with lock_i = 1 for 3 cycles while port 1 requests continuously -> gnt_o = 01,01,01. Port 0 then drops req_i -> the lock releases and port 1 is granted 2 cycles after port 0's last grant (one idle cycle), with no rvalid or SRAM access in the idle cycle.
- Byte enables: port 0 writes be = 0x0F, data 0x11223344_55667788 over a zeroed word, then reads -> rdata_o = 0x00000000_55667788.
- Reset mid-read: a read is granted, and rst_i is asserted in the following cycle -> rvalid_o stays 0. After release, prio_q = 0.
